// File: rtl/euclid_array_top.sv
// Avalon-MM point-pair distance accelerator; EUCLID_SQRT_EN makes RESULT floor(sqrt(dist^2)).
// Latency: reads 1 cycle; runs take 4 cycles per enabled and 1 per masked channel, plus FINISH. Waitrequest is tied 0.
module euclid_array_top #(
  parameter int NUM_CH  = 4,
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              slaveread,
  input  logic [ADDR_W-1:0] slaveaddress,
  input  logic              slavewrite,
  input  logic [31:0]       slavewritedata,
  output logic              slavereaddatavalid,
  output logic              slavewaitrequest,
  output logic [31:0]       slavereaddata,
  output logic              irq
);

  localparam int AW  = 2*COORD_W+3;
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CH-1);
`ifdef EUCLID_SQRT_EN
  localparam int NIT = (AW+1)/2;
  localparam int CW  = $clog2(NIT);
  localparam logic SQRT_BIT = 1'b1;
`else
  localparam logic SQRT_BIT = 1'b0;
`endif
  localparam logic [31:0] INFO = {15'd0, SQRT_BIT, 8'(COORD_W), 8'(NUM_CH)};

  typedef enum logic [2:0] {IDLE, LOAD, MULX, MULY, WRITE, SKIP, FINISH, SQRT} state_t;

  state_t                    state_q, state_d;
  logic [CHW-1:0]            ch_q, ch_d, ch_nxt;
  logic                      ie_q, ie_d, done_q, done_d, err_q, err_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [COORD_W-1:0]        x1_q [NUM_CH], x1_d [NUM_CH];
  logic [COORD_W-1:0]        x2_q [NUM_CH], x2_d [NUM_CH];
  logic [COORD_W-1:0]        y1_q [NUM_CH], y1_d [NUM_CH];
  logic [COORD_W-1:0]        y2_q [NUM_CH], y2_d [NUM_CH];
  logic [31:0]               res_q [NUM_CH], res_d [NUM_CH];
  logic signed [COORD_W:0]   dx_q, dx_d, dy_q, dy_d, mul_op;
  logic signed [2*COORD_W+1:0] prod;
  logic [AW-1:0]             acc_q, acc_d;
  logic                      rvalid_q, rvalid_d, irq_q, irq_d;
  logic [31:0]               rdata_q, rdata_d;
`ifdef EUCLID_SQRT_EN
  logic [2*NIT-1:0]          rad_q, rad_d;
  logic [NIT-1:0]            root_q, root_d;
  logic [NIT+1:0]            rem_q, rem_d, rem_sh, trial;
  logic [CW-1:0]             cnt_q, cnt_d;
`else
  logic [63:0]               acc_ext;
`endif

  logic [ADDR_W-4:0] blk;
  logic [2:0]        off;
  logic              busy, ctl_sel, start, err_set;
  logic              unused_wd;

  assign blk     = slaveaddress[ADDR_W-1:3];
  assign off     = slaveaddress[2:0];
  assign ctl_sel = (blk == '0);
  assign busy    = (state_q != IDLE);
  assign ch_nxt  = ch_q + CHW'(1);
  assign mul_op  = (state_q == MULY) ? dy_q : dx_q;
  assign prod    = mul_op * mul_op;
  assign unused_wd = ^slavewritedata;

  always_comb begin
    state_d = state_q;  ch_d = ch_q;
    ie_d = ie_q;  mask_d = mask_q;
    x1_d = x1_q;  x2_d = x2_q;  y1_d = y1_q;  y2_d = y2_q;  res_d = res_q;
    dx_d = dx_q;  dy_d = dy_q;  acc_d = acc_q;
    start = 1'b0;  err_set = 1'b0;
    done_d = done_q;  err_d = err_q;
`ifdef EUCLID_SQRT_EN
    rad_d = rad_q;  root_d = root_q;  rem_d = rem_q;  cnt_d = cnt_q;
    rem_sh = {rem_q[NIT-1:0], rad_q[2*NIT-1 -: 2]};
    trial  = {root_q, 2'b01};
`else
    acc_ext = 64'(acc_q);
`endif

    // Coordinates and mask are frozen while a run is in flight.
    if (slavewrite) begin
      if (ctl_sel) begin
        case (off)
          3'd0: begin
            ie_d = slavewritedata[1];
            if (slavewritedata[0]) begin
              if (busy) err_set = 1'b1;
              else      start   = 1'b1;
            end
          end
          3'd1: begin
            if (slavewritedata[1]) done_d = 1'b0;
            if (slavewritedata[2]) err_d  = 1'b0;
          end
          3'd2: begin
            if (busy) err_set = 1'b1;
            else      mask_d  = slavewritedata[NUM_CH-1:0];
          end
          default: ;
        endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (blk == (ADDR_W-3)'(c+1) && off < 3'd4) begin
          if (busy) err_set = 1'b1;
          else begin
            case (off)
              3'd0:    x1_d[c] = slavewritedata[COORD_W-1:0];
              3'd1:    x2_d[c] = slavewritedata[COORD_W-1:0];
              3'd2:    y1_d[c] = slavewritedata[COORD_W-1:0];
              default: y2_d[c] = slavewritedata[COORD_W-1:0];
            endcase
          end
        end
      end
    end
    if (err_set) err_d = 1'b1;

    case (state_q)
      IDLE: if (start) begin
        ch_d    = '0;
        state_d = mask_q[0] ? LOAD : SKIP;
      end
      LOAD: begin
        dx_d = {x1_q[ch_q][COORD_W-1], x1_q[ch_q]} - {x2_q[ch_q][COORD_W-1], x2_q[ch_q]};
        dy_d = {y1_q[ch_q][COORD_W-1], y1_q[ch_q]} - {y2_q[ch_q][COORD_W-1], y2_q[ch_q]};
        state_d = MULX;
      end
      MULX: begin
        acc_d   = {1'b0, prod};
        state_d = MULY;
      end
      MULY: begin
        acc_d = acc_q + {1'b0, prod};
`ifdef EUCLID_SQRT_EN
        rad_d   = (2*NIT)'(acc_d);
        root_d  = '0;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = SQRT;
`else
        state_d = WRITE;
`endif
      end
`ifdef EUCLID_SQRT_EN
      // Restoring square root, one result bit (two radicand bits) per cycle.
      SQRT: begin
        rad_d = rad_q << 2;
        cnt_d = cnt_q + CW'(1);
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[NIT-2:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[NIT-2:0], 1'b0};
        end
        if (cnt_q == CW'(NIT-1)) state_d = WRITE;
      end
`endif
      WRITE, SKIP: begin
        if (state_q == WRITE) begin
`ifdef EUCLID_SQRT_EN
          res_d[ch_q] = 32'(root_q);
`else
          res_d[ch_q] = (|acc_ext[63:32]) ? 32'hFFFF_FFFF : acc_ext[31:0];
`endif
        end
        if (ch_q == LAST_CH) state_d = FINISH;
        else begin
          ch_d    = ch_nxt;
          state_d = mask_q[ch_nxt] ? LOAD : SKIP;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rvalid_d = slaveread;
    rdata_d  = '0;
    if (slaveread) begin
      if (ctl_sel) begin
        case (off)
          3'd0:    rdata_d = {30'd0, ie_q, 1'b0};
          3'd1:    rdata_d = {29'd0, err_q, done_q, busy};
          3'd2:    rdata_d = 32'(mask_q);
          3'd3:    rdata_d = INFO;
          default: rdata_d = '0;
        endcase
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (blk == (ADDR_W-3)'(c+1)) begin
          case (off)
            3'd0:    rdata_d = 32'(x1_q[c]);
            3'd1:    rdata_d = 32'(x2_q[c]);
            3'd2:    rdata_d = 32'(y1_q[c]);
            3'd3:    rdata_d = 32'(y2_q[c]);
            3'd4:    rdata_d = res_q[c];
            default: rdata_d = '0;
          endcase
        end
      end
    end

    irq_d = done_q & ie_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
      x1_q     <= '{default: '0};
      x2_q     <= '{default: '0};
      y1_q     <= '{default: '0};
      y2_q     <= '{default: '0};
      res_q    <= '{default: '0};
      dx_q     <= '0;
      dy_q     <= '0;
      acc_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
`ifdef EUCLID_SQRT_EN
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      ie_q     <= ie_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
      res_q    <= res_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      acc_q    <= acc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
`ifdef EUCLID_SQRT_EN
      rad_q    <= rad_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign slavereaddatavalid = rvalid_q;
  assign slavereaddata      = rdata_q;
  assign slavewaitrequest   = 1'b0;
  assign irq                = irq_q;

endmodule

// File: tb/tb_euclid_array_top.sv
// Directed bench for euclid_array_top; expected results switch with EUCLID_SQRT_EN.
module tb_euclid_array_top;

`ifdef EUCLID_SQRT_EN
  localparam logic [31:0] R_BASIC = 32'd5;
  localparam logic [31:0] R_SIGN  = 32'd12;
  localparam logic [31:0] R_SAT   = 32'd92680;
  localparam logic [31:0] R_CH3   = 32'd9;
  localparam int          CYC1    = 26;
  localparam logic [31:0] INFO    = 32'h0001_1004;
`else
  localparam logic [31:0] R_BASIC = 32'd25;
  localparam logic [31:0] R_SIGN  = 32'd144;
  localparam logic [31:0] R_SAT   = 32'hFFFF_FFFF;
  localparam logic [31:0] R_CH3   = 32'd81;
  localparam int          CYC1    = 8;
  localparam logic [31:0] INFO    = 32'h0000_1004;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        slaveread, slavewrite;
  logic [5:0]  slaveaddress;
  logic [31:0] slavewritedata;
  logic        slavereaddatavalid, slavewaitrequest, irq;
  logic [31:0] slavereaddata;

  int n_chk  = 0;
  int n_pass = 0;

  euclid_array_top dut (
    .clk                (clk),
    .reset              (reset),
    .slaveread          (slaveread),
    .slaveaddress       (slaveaddress),
    .slavewrite         (slavewrite),
    .slavewritedata     (slavewritedata),
    .slavereaddatavalid (slavereaddatavalid),
    .slavewaitrequest   (slavewaitrequest),
    .slavereaddata      (slavereaddata),
    .irq                (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    slavewrite = 1'b1; slaveaddress = a; slavewritedata = d;
    @(negedge clk);
    slavewrite = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d, output logic v);
    slaveread = 1'b1; slaveaddress = a;
    @(negedge clk);
    slaveread = 1'b0;
    d = slavereaddata;
    v = slavereaddatavalid;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    rd(a, d, v);
    chk(tag, v ? d : 32'hDEAD_BEEF, exp);
  endtask

  // Streams STATUS reads; n counts samples with BUSY set, irq_pre is irq on the last busy sample.
  task automatic poll(output int n, output logic irq_pre);
    n = 0; irq_pre = irq;
    slaveread = 1'b1; slaveaddress = 6'd1;
    @(negedge clk);
    while (slavereaddata[0] && n < 500) begin
      irq_pre = irq;
      n++;
      @(negedge clk);
    end
    slaveread = 1'b0;
  endtask

  initial begin
    int          n;
    logic        ip;
    logic [31:0] d;
    logic        v;
    reset = 1'b1; slaveread = 1'b0; slavewrite = 1'b0;
    slaveaddress = '0; slavewritedata = '0;
    repeat (2) @(negedge clk);
    chk("rst_rvalid", {31'd0, slavereaddatavalid}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    rd_chk("rst_status", 6'd1, 32'd0);
    rd_chk("info", 6'd3, INFO);
    rd_chk("rst_res2", 6'd28, 32'd0);

    // Basic run on channel 0
    wr(6'd8, 32'd3); wr(6'd9, 32'd0); wr(6'd10, 32'd4); wr(6'd11, 32'd0);
    wr(6'd2, 32'h1);
    wr(6'd0, 32'h1);
    poll(n, ip);
    chk("basic_busy_cycles", 32'(n), 32'(CYC1));
    @(negedge clk);
    chk("idle_rvalid", {31'd0, slavereaddatavalid}, 32'd0);
    rd_chk("basic_res0", 6'd12, R_BASIC);
    rd_chk("basic_status", 6'd1, 32'h2);
    rd_chk("basic_res1", 6'd20, 32'd0);
    wr(6'd1, 32'h2);

    // Signed coordinates on channel 2
    wr(6'd24, 32'h0000_FFFB); wr(6'd25, 32'd7); wr(6'd26, 32'hFFFF_FFFF); wr(6'd27, 32'h0000_FFFF);
    wr(6'd2, 32'h4);
    wr(6'd0, 32'h1);
    poll(n, ip);
    rd_chk("signed_res2", 6'd28, R_SIGN);
    rd_chk("masked_res0_kept", 6'd12, R_BASIC);
    wr(6'd1, 32'h2);

    // Saturation on channel 1
    wr(6'd16, 32'h7FFF); wr(6'd17, 32'h8000); wr(6'd18, 32'h7FFF); wr(6'd19, 32'h8000);
    wr(6'd2, 32'h2);
    wr(6'd0, 32'h1);
    poll(n, ip);
    rd_chk("sat_res1", 6'd20, R_SAT);
    wr(6'd1, 32'h2);
    rd_chk("clear_status", 6'd1, 32'd0);

    // Errors while busy and interrupt timing
    wr(6'd2, 32'hF);
    wr(6'd32, 32'd9);
    wr(6'd0, 32'h3);
    wr(6'd0, 32'h3);
    wr(6'd32, 32'h55);
    poll(n, ip);
    chk("irq_low_with_done", {31'd0, ip}, 32'd0);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd_chk("err_status", 6'd1, 32'h6);
    rd_chk("err_x1_kept", 6'd32, 32'd9);
    rd_chk("err_res3", 6'd36, R_CH3);
    wr(6'd1, 32'h6);
    rd_chk("w1c_status", 6'd1, 32'd0);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    repeat (40) @(negedge clk);
    rd_chk("single_run", 6'd1, 32'd0);

    // Empty mask
    wr(6'd2, 32'h0);
    wr(6'd0, 32'h3);
    poll(n, ip);
    chk("mask0_cycles", 32'(n), 32'd5);
    rd_chk("mask0_status", 6'd1, 32'h2);
    rd_chk("mask0_res0", 6'd12, R_BASIC);
    rd_chk("mask0_res3", 6'd36, R_CH3);
    chk("mask0_irq", {31'd0, irq}, 32'd1);

    // Reset in the middle of MULX
    wr(6'd2, 32'h1);
    wr(6'd0, 32'h3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_irq", {31'd0, irq}, 32'd0);
    chk("midrst_rvalid", {31'd0, slavereaddatavalid}, 32'd0);
    reset = 1'b0;
    rd(6'd12, d, v);
    chk("postrst_rvalid", {31'd0, v}, 32'd1);
    chk("postrst_res0", d, 32'd0);
    rd_chk("postrst_status", 6'd1, 32'd0);
    rd_chk("postrst_mask", 6'd2, 32'd0);
    rd_chk("postrst_ctrl", 6'd0, 32'd0);
    rd_chk("postrst_x1", 6'd8, 32'd0);
    rd_chk("postrst_res3", 6'd36, 32'd0);
    chk("postrst_irq", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
